// File: rtl/full_adder_subtractor.sv
// ---------------------------------------------------------------------------
// full_adder_subtractor
//   Registered adder/subtractor with a WIDTH-bit result and carry/borrow-out.
//   Built from 1-bit full-adder cells grouped into BLOCK-bit carry-select
//   segments. The datapath is combinational from the pins to the output
//   registers, so the result appears one clock after the operands.
//
// Parameters
//   WIDTH  operand/result width, 24 or 32
//   BLOCK  carry-select segment size in bits, must divide WIDTH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid this cycle
//   sub        0 = add, 1 = subtract
//   in_1       operand A (minuend when subtracting)
//   in_2       operand B (subtrahend when subtracting)
//   c_in       carry-in (add) / borrow-in (subtract)
//   out        registered result
//   c_out      registered carry-out (add) / borrow-out (subtract)
//   ovf        registered signed two's-complement overflow
//   out_valid  result valid
//
// Handshake: in_valid=1 at a rising edge captures the operands; out_valid
// is 1 exactly in the cycle after such an edge. There is no back-pressure;
// an operation is accepted every cycle. With in_valid=0 the result
// registers hold and out_valid drops.
// ---------------------------------------------------------------------------
module full_adder_subtractor #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             c_in,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
  output logic             ovf,
  output logic             out_valid
);

  localparam int NSEG = WIDTH / BLOCK;

  if ((WIDTH != 24) && (WIDTH != 32)) begin : g_bad_width
    $error("full_adder_subtractor: WIDTH must be 24 or 32");
  end
  if ((WIDTH % BLOCK) != 0) begin : g_bad_block
    $error("full_adder_subtractor: BLOCK must divide WIDTH");
  end

  // 1-bit full-adder cell: returns {carry, sum}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

  // Subtraction is a + ~b + ~c_in; the raw carry is the inverted borrow.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] sum;
  logic [NSEG:0]    seg_c;

  assign b_eff   = sub ? ~in_2 : in_2;
  assign cin_eff = sub ? ~c_in : c_in;
  assign seg_c[0] = cin_eff;

  for (genvar s = 0; s < NSEG; s++) begin : g_seg
    if (s == 0) begin : g_ripple
      // Lowest segment sees the real carry-in, so no select is needed.
      logic [BLOCK:0]   c;
      logic [BLOCK-1:0] r;
      assign c[0] = seg_c[0];
      for (genvar i = 0; i < BLOCK; i++) begin : g_bit
        assign {c[i+1], r[i]} = fa(in_1[s*BLOCK+i], b_eff[s*BLOCK+i], c[i]);
      end
      assign sum[s*BLOCK +: BLOCK] = r;
      assign seg_c[s+1]            = c[BLOCK];
    end else begin : g_select
      // Both carry hypotheses ripple in parallel; the incoming segment
      // carry picks one once it arrives.
      logic [BLOCK:0]   c0, c1;
      logic [BLOCK-1:0] r0, r1;
      assign c0[0] = 1'b0;
      assign c1[0] = 1'b1;
      for (genvar i = 0; i < BLOCK; i++) begin : g_bit
        assign {c0[i+1], r0[i]} = fa(in_1[s*BLOCK+i], b_eff[s*BLOCK+i], c0[i]);
        assign {c1[i+1], r1[i]} = fa(in_1[s*BLOCK+i], b_eff[s*BLOCK+i], c1[i]);
      end
      assign sum[s*BLOCK +: BLOCK] = seg_c[s] ? r1 : r0;
      assign seg_c[s+1]            = seg_c[s] ? c1[BLOCK] : c0[BLOCK];
    end
  end

  logic carry_res;
  logic ovf_res;

  assign carry_res = sub ? ~seg_c[NSEG] : seg_c[NSEG];
  // Overflow: effective operands share a sign and the result sign differs.
  assign ovf_res   = (in_1[WIDTH-1] == b_eff[WIDTH-1]) &&
                     (sum[WIDTH-1] != in_1[WIDTH-1]);

  // Result registers only load on accepted operands, so anything on the
  // operand pins while in_valid=0 never reaches the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out   <= sum;
        c_out <= carry_res;
        ovf   <= ovf_res;
      end
    end
  end

endmodule

// File: tb/tb_full_adder_subtractor.sv
// ---------------------------------------------------------------------------
// tb_full_adder_subtractor
//   Bench for full_adder_subtractor with one 32-bit and one 24-bit instance.
//   Drivers push hand-computed {out, c_out, ovf} into per-instance expected
//   queues; monitors pop and compare on every out_valid cycle.
// ---------------------------------------------------------------------------
module tb_full_adder_subtractor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        v32, sub32, cin32;
  logic [31:0] a32, b32;
  logic [31:0] out32;
  logic        c32, ovf32, ov32;

  logic        v24, sub24, cin24;
  logic [23:0] a24, b24;
  logic [23:0] out24;
  logic        c24, ovf24, ov24;

  full_adder_subtractor #(.WIDTH(32), .BLOCK(8)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .sub(sub32),
    .in_1(a32), .in_2(b32), .c_in(cin32),
    .out(out32), .c_out(c32), .ovf(ovf32), .out_valid(ov32)
  );

  full_adder_subtractor #(.WIDTH(24), .BLOCK(8)) u24 (
    .clk(clk), .rst_n(rst_n), .in_valid(v24), .sub(sub24),
    .in_1(a24), .in_2(b24), .c_in(cin24),
    .out(out24), .c_out(c24), .ovf(ovf24), .out_valid(ov24)
  );

  // ---------------- scoreboard ----------------
  logic [33:0] exp32_q[$];
  logic [25:0] exp24_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ov32) begin
      if (exp32_q.size() == 0) begin
        check("u32 unexpected out_valid", 64'(ov32), 64'd0);
      end else begin
        logic [33:0] e;
        e = exp32_q.pop_front();
        check("u32 {out,c_out,ovf}", 64'({out32, c32, ovf32}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov24) begin
      if (exp24_q.size() == 0) begin
        check("u24 unexpected out_valid", 64'(ov24), 64'd0);
      end else begin
        logic [25:0] e;
        e = exp24_q.pop_front();
        check("u24 {out,c_out,ovf}", 64'({out24, c24, ovf24}), 64'(e));
      end
    end
  end

  // ---------------- drivers ----------------
  // Called at posedge+1; leaves in_valid asserted so calls chain back-to-back.
  task automatic issue32(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic [31:0] eo, input logic ec,
                         input logic eov);
    sub32 = s; a32 = a; b32 = b; cin32 = ci; v32 = 1'b1;
    exp32_q.push_back({eo, ec, eov});
    @(posedge clk); #1;
  endtask

  task automatic issue24(input logic s, input logic [23:0] a, input logic [23:0] b,
                         input logic ci, input logic [23:0] eo, input logic ec,
                         input logic eov);
    sub24 = s; a24 = a; b24 = b; cin24 = ci; v24 = 1'b1;
    exp24_q.push_back({eo, ec, eov});
    @(posedge clk); #1;
  endtask

  // Idle cycle with junk on the operand pins.
  task automatic idle();
    v32 = 1'b0; v24 = 1'b0;
    sub32 = 1'($urandom_range(0, 1)); a32 = $urandom; b32 = $urandom; cin32 = 1'b1;
    sub24 = 1'($urandom_range(0, 1)); a24 = 24'($urandom); b24 = 24'($urandom); cin24 = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    v32 = 0; sub32 = 0; a32 = 0; b32 = 0; cin32 = 0;
    v24 = 0; sub24 = 0; a24 = 0; b24 = 0; cin24 = 0;

    #1;
    check("reset u32 outputs", 64'({out32, c32, ovf32, ov32}), 64'd0);
    check("reset u24 outputs", 64'({out24, c24, ovf24, ov24}), 64'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 32-bit adds
    issue32(0, 32'd12,         32'd13, 0, 32'd25,         0, 0);
    issue32(0, 32'hFFFFFFFF,   32'd1,  0, 32'h0,          1, 0);
    issue32(0, 32'h7FFFFFFF,   32'd1,  0, 32'h80000000,   0, 1);
    issue32(0, 32'hFFFFFFFF,   32'd0,  1, 32'h0,          1, 0);
    issue32(0, 32'h000000FF,   32'd1,  0, 32'h00000100,   0, 0);
    issue32(0, 32'h00FFFFFF,   32'd1,  0, 32'h01000000,   0, 0);
    // 32-bit subtracts
    issue32(1, 32'h0,          32'd1,  0, 32'hFFFFFFFF,   1, 0);
    issue32(1, 32'h5A5A5A5A,   32'h5A5A5A5A, 0, 32'h0,    0, 0);
    issue32(1, 32'h12345678,   32'hFFFFFFFF, 1, 32'h12345678, 1, 0);
    // back-to-back throughput
    issue32(0, 32'd89,         32'd134, 0, 32'd223,       0, 0);
    issue32(1, 32'd134,        32'd89,  0, 32'd45,        0, 0);
    idle();
    check("u32 idle out_valid", 64'(ov32), 64'd0);
    check("u32 idle hold", 64'({out32, c32, ovf32}), 64'({32'd45, 1'b0, 1'b0}));
    idle();
    check("u32 idle hold 2", 64'(out32), 64'd45);

    // 24-bit
    issue24(1, 24'd46,         24'd50,      0, 24'hFFFFFC, 1, 0);
    issue24(1, 24'h800000,     24'd1,       0, 24'h7FFFFF, 0, 1);
    issue24(1, 24'hB4851F,     24'hB4851F,  1, 24'hFFFFFF, 1, 0);
    issue24(0, 24'hFFFFFF,     24'd1,       0, 24'h0,      1, 0);
    issue24(0, 24'h400000,     24'h400000,  0, 24'h800000, 0, 1);
    issue24(1, 24'h0,          24'd1,       0, 24'hFFFFFF, 1, 0);
    idle();
    check("u24 idle out_valid", 64'(ov24), 64'd0);
    check("u24 idle hold", 64'(out24), 64'hFFFFFF);

    // Reset mid-operation: transaction presented while rst_n falls is lost.
    sub32 = 0; a32 = 32'd7; b32 = 32'd9; cin32 = 0; v32 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async reset u32", 64'({out32, c32, ovf32, ov32}), 64'd0);
    check("async reset u24", 64'({out24, c24, ovf24, ov24}), 64'd0);
    @(posedge clk); #1;
    check("held in reset u32", 64'({out32, c32, ovf32, ov32}), 64'd0);
    v32 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-release u32 valid", 64'(ov32), 64'd0);
    check("post-release u32 out", 64'(out32), 64'd0);
    issue32(0, 32'd100, 32'd23, 1, 32'd124, 0, 0);
    idle();
    idle();

    check("u32 queue drained", 64'(exp32_q.size()), 64'd0);
    check("u24 queue drained", 64'(exp24_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound.
  initial begin
    #100000;
    fails++;
    $display("FAIL timeout: simulation exceeded time bound");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/full_adder_subtractor.md
Name: full_adder_subtractor

Overview:
- Registered, width-parameterised adder/subtractor.
- One instance covers the roles of the 24-bit adder, 32-bit adder and 24-bit subtractor used by the Booth multiplier datapaths: WIDTH selects 24 or 32, and the mode input selects add or subtract.
- Computes the WIDTH-bit result plus carry/borrow-out in one clock.

Parameters:
- WIDTH, 32, operand and result width; supported values 24 and 32; any other value is a elaboration error.
- BLOCK, 8, carry-select block size in bits; must divide WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- sub  input  1  0 = add, 1 = subtract
- in_1  input  WIDTH  operand A (minuend when sub=1)
- in_2  input  WIDTH  operand B (subtrahend when sub=1)
- c_in  input  1  carry-in (add) / borrow-in (subtract)
- out  output  WIDTH  registered result
- c_out  output  1  registered carry-out (add) / borrow-out (subtract)
- ovf  output  1  registered signed two's-complement overflow
- out_valid  output  1  result valid

Behaviour:
- Reset
  - Asynchronous on rst_n low: out=0, c_out=0, ovf=0, out_valid=0.
  - Outputs hold these values while rst_n=0.
  - Release is synchronous to the next rising clk edge.
- Latency and handshake
  - Fixed latency of 1 cycle; no back-pressure; a new operation is accepted every cycle.
  - On each rising edge with in_valid=1: out, c_out and ovf load the new result, and out_valid<=1.
  - On an edge with in_valid=0: out_valid<=0, and out, c_out and ovf hold their previous values.
- Add (sub=0)
  - {c_out,out} = in_1 + in_2 + c_in, unsigned, with the sum taken at WIDTH+1 bits.
- Subtract (sub=1)
  - out = (in_1 - in_2 - c_in) mod 2^WIDTH.
  - c_out = borrow = 1 exactly when unsigned in_1 < in_2 + c_in.
  - Implemented as in_1 + ~in_2 + ~c_in; c_out is the inverted raw carry.
- Overflow
  - ovf=1 when the operands' MSBs match (for subtract, in_1 MSB vs inverted in_2 MSB) and the result MSB differs from them; otherwise ovf=0.
  - Equivalent to the XOR of the carry into and the carry out of the MSB.
- Structure
  - Built from 1-bit full-adder cells grouped into BLOCK-bit carry-select segments.
  - Each segment precomputes results for carry 0 and carry 1; the incoming segment carry selects between them.
  - The lowest segment takes the effective carry-in directly.
  - Whole datapath is combinational between the input pins and the output registers; no input registering.
- Width rules
  - No sign extension internally.
  - Callers needing a WIDTH+1 sign bit replicate out[WIDTH-1] externally.
- Boundary conditions
  - All-ones + 1 wraps to 0 with c_out=1.
  - 0 - 1 wraps to all-ones with borrow=1.
  - Equal operands on subtract with c_in=0 give 0, borrow=0, ovf=0.
  - c_in=1 with in_2 all-ones on subtract gives borrow=1 for every in_1.
- Reset mid-operation: a transaction presented in the cycle rst_n falls is discarded; out_valid stays 0 until the first in_valid edge after release.
- X on sub, in_1, in_2 or c_in when in_valid=0 must not propagate to the outputs.

Test Plan:
- WIDTH=32, add: in_1=12, in_2=13, c_in=0 -> one cycle later out=25, c_out=0, ovf=0, out_valid=1.
- WIDTH=32, add: in_1=0xFFFFFFFF, in_2=1, c_in=0 -> out=0, c_out=1, ovf=0.
- WIDTH=32, add: in_1=0x7FFFFFFF, in_2=1 -> out=0x80000000, c_out=0, ovf=1.
- WIDTH=24, subtract: in_1=46, in_2=50, c_in=0 -> out=0xFFFFFC, c_out(borrow)=1, ovf=0.
- WIDTH=24, subtract: in_1=0x800000, in_2=1, c_in=0 -> out=0x7FFFFF, borrow=0, ovf=1.
- WIDTH=24, subtract: in_1=in_2=0xB4851F, c_in=1 -> out=0xFFFFFF, borrow=1.
- Throughput: back-to-back in_valid with 89+134 then 134-89 (WIDTH=32) -> out=223 then 45 on consecutive cycles.
- Hold on idle: drop in_valid -> out_valid=0 and out holds 45.
- Reset: assert rst_n=0 between clock edges with in_valid=1 -> outputs go 0 immediately without a clock; after release, out_valid stays 0 until the next in_valid edge.
